// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and its consumer.
// slave = the result stage itself; master = the ALU/consumer side that drives it.
interface alu_result_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carryout;
    logic             alu_zero;
    logic             alu_overflow;
    logic [2:0]       alu_command;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_flags;
    logic [2:0]       out_command;

    modport slave (
        input  in_valid, alu_result, alu_carryout, alu_zero, alu_overflow, alu_command,
        output in_ready,
        output out_valid, out_result, out_flags, out_command,
        input  out_ready
    );

    modport master (
        output in_valid, alu_result, alu_carryout, alu_zero, alu_overflow, alu_command,
        input  in_ready,
        input  out_valid, out_result, out_flags, out_command,
        output out_ready
    );
endinterface

// File: rtl/alu_result_stage.sv
// Two-entry skid buffer behind the ALU with sticky ADD/SUB carry/overflow and a pop counter.
// Latency 1 cycle when empty; in_ready depends on registered occupancy only, never on out_ready.
module alu_result_stage #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_result_stage_if.slave    bus,
    input  logic                 clear_sticky,
    output logic                 sticky_carry,
    output logic                 sticky_ovf,
    output logic [CNT_WIDTH-1:0] result_count
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [2:0]       flags;    // {overflow, zero, carryout}
        logic [2:0]       command;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_SUB = 3'd1;

    state_t                state_q;
    entry_t                head_q;
    entry_t                tail_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  sticky_carry_q, sticky_carry_d;
    logic                  sticky_ovf_q,   sticky_ovf_d;
    logic [CNT_WIDTH-1:0]  result_count_q, result_count_d;

    entry_t                in_entry;
    logic                  push;
    logic                  pop;
    logic                  arith_push;

    assign in_entry = {bus.alu_result,
                       bus.alu_overflow, bus.alu_zero, bus.alu_carryout,
                       bus.alu_command};

    assign push = bus.in_valid & in_ready_q;
    assign pop  = out_valid_q & bus.out_ready;

    // Occupancy FSM; in_ready/out_valid are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_q      <= in_entry;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        tail_q     <= in_entry;
                        state_q    <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (!push && pop) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end else if (push && pop) begin
                        head_q <= in_entry;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_q     <= tail_q;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // A setting push beats a simultaneous clear.
    assign arith_push = push & ((bus.alu_command == CMD_ADD) | (bus.alu_command == CMD_SUB));

    always_comb begin
        sticky_carry_d = (sticky_carry_q & ~clear_sticky) | (arith_push & bus.alu_carryout);
        sticky_ovf_d   = (sticky_ovf_q   & ~clear_sticky) | (arith_push & bus.alu_overflow);
        result_count_d = result_count_q;
        if (pop) begin
            result_count_d = result_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_carry_q <= 1'b0;
            sticky_ovf_q   <= 1'b0;
            result_count_q <= '0;
        end else begin
            sticky_carry_q <= sticky_carry_d;
            sticky_ovf_q   <= sticky_ovf_d;
            result_count_q <= result_count_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = head_q.result;
    assign bus.out_flags   = head_q.flags;
    assign bus.out_command = head_q.command;

    assign sticky_carry    = sticky_carry_q;
    assign sticky_ovf      = sticky_ovf_q;
    assign result_count    = result_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomised and directed checks of alu_result_stage against a queue-based reference model.
module tb_alu_result_stage;
    localparam int W  = 32;
    localparam int CW = 16;

    typedef struct packed {
        logic [W-1:0] res;
        logic [2:0]   flg;
        logic [2:0]   cmd;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear_sticky = 1'b0;
    logic          sticky_carry;
    logic          sticky_ovf;
    logic [CW-1:0] result_count;

    alu_result_stage_if #(.WIDTH(W)) bus ();

    alu_result_stage #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .clear_sticky (clear_sticky),
        .sticky_carry (sticky_carry),
        .sticky_ovf   (sticky_ovf),
        .result_count (result_count)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of held entries plus sticky bits and a pop counter.
    ent_t          mq[$];
    logic          m_sc;
    logic          m_so;
    logic [CW-1:0] m_cnt;

    int vectors = 0;
    int errors  = 0;

    task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_sc  = 1'b0;
        m_so  = 1'b0;
        m_cnt = '0;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] r, input logic [2:0] c,
                         input logic co, input logic z, input logic ov,
                         input logic ordy, input logic clr);
        bus.in_valid     = v;
        bus.alu_result   = r;
        bus.alu_command  = c;
        bus.alu_carryout = co;
        bus.alu_zero     = z;
        bus.alu_overflow = ov;
        bus.out_ready    = ordy;
        clear_sticky     = clr;
    endtask

    // One clock: compare at the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        logic push, pop, clr, arith;
        ent_t e, dropped;
        @(negedge clk);
        expect_eq("in_ready",  bus.in_ready,  64'(mq.size() < 2));
        expect_eq("out_valid", bus.out_valid, 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            expect_eq("out_result",  bus.out_result,  mq[0].res);
            expect_eq("out_flags",   bus.out_flags,   mq[0].flg);
            expect_eq("out_command", bus.out_command, mq[0].cmd);
        end
        expect_eq("sticky_carry", sticky_carry, m_sc);
        expect_eq("sticky_ovf",   sticky_ovf,   m_so);
        expect_eq("result_count", result_count, m_cnt);
        push  = bus.in_valid && (mq.size() < 2);
        pop   = (mq.size() > 0) && bus.out_ready;
        clr   = clear_sticky;
        e.res = bus.alu_result;
        e.flg = {bus.alu_overflow, bus.alu_zero, bus.alu_carryout};
        e.cmd = bus.alu_command;
        arith = push && (e.cmd == 3'd0 || e.cmd == 3'd1);
        @(posedge clk);
        if (pop) begin
            dropped = mq.pop_front();
            m_cnt   = m_cnt + 1'b1;
        end
        if (push) mq.push_back(e);
        m_sc = (m_sc && !clr) || (arith && e.flg[0]);
        m_so = (m_so && !clr) || (arith && e.flg[2]);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int n;
        model_reset();
        drive(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        expect_eq("rst_in_ready",  bus.in_ready,    1);
        expect_eq("rst_out_valid", bus.out_valid,   0);
        expect_eq("rst_result",    bus.out_result,  0);
        expect_eq("rst_flags",     bus.out_flags,   0);
        expect_eq("rst_command",   bus.out_command, 0);
        expect_eq("rst_count",     result_count,    0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single ADD result, 1-cycle latency, counted once popped.
        drive(1'b1, 32'h5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        idle(1);
        expect_eq("t1_count", result_count, 1);
        idle(1);

        // Consumer stalled: A and B held, C refused, then drained in order.
        drive(1'b1, 32'hA, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'hB, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'hC, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
        expect_eq("t2_in_ready_full", bus.in_ready, 0);
        idle(3);
        expect_eq("t2_count", result_count, 3);

        // ONE with simultaneous push and pop replaces the head.
        drive(1'b1, 32'hE, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'hD, 3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); cycle();
        expect_eq("t3_head", bus.out_result, 32'hD);
        expect_eq("t3_in_ready", bus.in_ready, 1);
        idle(2);

        // ADD overflow sets sticky_ovf; carry on a non-arithmetic command is ignored.
        drive(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); cycle();
        drive(1'b1, 32'h80000000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h1234, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
        idle(1);
        expect_eq("t4_sticky_ovf",   sticky_ovf,   1);
        expect_eq("t4_sticky_carry", sticky_carry, 0);

        // Clear collides with a setting SUB push: set wins; a lone clear then clears.
        drive(1'b1, 32'h0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); cycle();
        expect_eq("t5_set_wins", sticky_carry, 1);
        drive(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); cycle();
        expect_eq("t5_cleared", sticky_carry, 0);
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            cycle();
        end
        idle(3);

        // Stream until the counter is near the top, then wrap it and reset while full.
        n = 0;
        while (m_cnt != 16'hFFFE && n < 70000) begin
            drive(1'b1, $urandom, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'b1, 1'b0);
            cycle();
            n++;
        end
        expect_eq("count_fffe", result_count, 16'hFFFE);
        drive(1'b1, 32'h11, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h22, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h33, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
        expect_eq("count_ffff", result_count, 16'hFFFF);
        drive(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
        expect_eq("count_wrap", result_count, 0);
        drive(1'b1, 32'h44, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h55, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
        expect_eq("pre_rst_full", bus.in_ready, 0);

        #2;
        reset = 1'b1;
        #1;
        expect_eq("arst_out_valid", bus.out_valid,  0);
        expect_eq("arst_in_ready",  bus.in_ready,   1);
        expect_eq("arst_result",    bus.out_result, 0);
        expect_eq("arst_count",     result_count,   0);
        expect_eq("arst_sc",        sticky_carry,   0);
        expect_eq("arst_so",        sticky_ovf,     0);
        model_reset();
        drive(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        idle(2);
        drive(1'b1, 32'h66, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); cycle();
        idle(2);
        expect_eq("post_rst_count", result_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
